// File: rtl/aes_pkg.sv
// Shared AES-128 primitives for the iterative encrypt and decrypt cores.
// S-box is computed as GF(2^8) inverse plus affine map rather than a table.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic {IDLE, ROUND} aes_enc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] get_rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_encrypt_key_step.sv
// One forward step of the AES-128 key schedule (combinational).
module aes_encrypt_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  // Word chaining: each new word folds in the one produced before it
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_iterative_core.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Exports the final round key so the decrypt side can run its inverse schedule.
//
//  state | meaning
//  IDLE  | waiting for cipher_new_en; outputs hold last result
//  ROUND | running rounds 1..10, one per clock; busy high
module aes_encrypt_iterative_core
  import aes_pkg::*;
#(
  parameter bit READY_PULSE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
  input  logic         cipher_new_en,
  output logic         busy,
  output logic         cipher_ready,
  output logic [127:0] cipher_text,
  output logic [127:0] round_key_10
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_enc_state_t fsm_q;
  logic [127:0]   state_q, key_q;
  logic [3:0]     round_q;
  logic           busy_q, ready_q;
  logic [127:0]   ct_q, rk10_q;

  logic [127:0]   sb, sr, mc, key_d, state_d;

  // Shared S-box bank for SubBytes
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb[8*i +: 8] = sbox(state_q[8*i +: 8]);
  end

  aes_encrypt_key_step u_key_step (
    .key_in  (key_q),
    .rcon    (get_rcon(round_q)),
    .key_out (key_d)
  );

  // Round function; the final round omits MixColumns
  always_comb begin
    sr      = shift_rows(sb);
    mc      = mix_columns(sr);
    state_d = (round_q == LAST_ROUND) ? (sr ^ key_d) : (mc ^ key_d);
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      ct_q    <= '0;
      rk10_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (READY_PULSE) ready_q <= 1'b0;
          if (cipher_new_en) begin
            state_q <= plain_text ^ cipher_key;
            key_q   <= cipher_key;
            round_q <= 4'd1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= state_d;
          key_q   <= key_d;
          if (round_q == LAST_ROUND) begin
            ct_q    <= state_d;
            rk10_q  <= key_d;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            round_q <= '0;
            fsm_q   <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign cipher_ready = ready_q;
  assign cipher_text  = ct_q;
  assign round_key_10 = rk10_q;

endmodule
